// File: rtl/fp_mul_pkg.sv
// ============================================================================
// Module      : fp_mul_pkg
// Description : Shared definitions for the pipelined floating-point
//               multiplier: rounding modes, flag indices, operand classes
//               and format-derived helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mul_pkg;

   // Rounding-mode encodings, sampled together with the operands
   localparam logic [1:0] RM_RNE = 2'd0;
   localparam logic [1:0] RM_RTZ = 2'd1;
   localparam logic [1:0] RM_RUP = 2'd2;
   localparam logic [1:0] RM_RDN = 2'd3;

   // Bit positions inside the 4-bit exception flag vector
   localparam int FLG_NV = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   // Operand classes; subnormals are folded into ZERO
   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   // Exponent bias for an exponent field of exp_w bits
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Magnitude bits (exponent and fraction) of the largest finite value
   function automatic logic [63:0] fp_max_finite(input int exp_w, input int frac_w);
      logic [63:0] v;
      v = ((64'd1 << (exp_w + frac_w)) - 64'd1) - (64'd1 << frac_w);
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_pipe_reg.sv
// ============================================================================
// Module      : fp_pipe_reg
// Description : Generic pipeline register with synchronous active-high
//               reset (clears to zero) and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Reset wins over the enable so a flush works even while stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fp_round_unit.sv
// ============================================================================
// Module      : fp_round_unit
// Description : Combinational rounding of a normalised mantissa given its
//               guard and sticky bits, the result sign and a rounding mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_unit
   import fp_mul_pkg::*;
#(
   parameter int MANT_W = 24
) (
   input  logic [MANT_W-1:0] mant_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   input  logic              sign_i,
   input  logic [1:0]        mode_i,
   output logic [MANT_W-1:0] mant_o,
   output logic              carry_o,
   output logic              inexact_o
);

   logic            inc;
   logic [MANT_W:0] sum;

   // Decide the increment, add it, and renormalise on a carry-out
   always_comb begin
      inc = 1'b0;
      case (mode_i)
         RM_RNE:  inc = guard_i & (sticky_i | mant_i[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = ~sign_i & (guard_i | sticky_i);
         default: inc =  sign_i & (guard_i | sticky_i);
      endcase
      sum       = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc};
      carry_o   = sum[MANT_W];
      mant_o    = sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
      inexact_o = guard_i | sticky_i;
   end

endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ============================================================================
// Module      : fp_mul_pipe
// Description : Four-stage pipelined floating-point multiplier with
//               valid/ready flow control, four rounding modes, special-value
//               overrides and exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic [EXP_W+FRAC_W:0]     Operand1,
   input  logic [EXP_W+FRAC_W:0]     Operand2,
   input  logic [1:0]                RoundMode,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic [EXP_W+FRAC_W:0]     Result,
   output logic [3:0]                Flags
);

   localparam int W   = 1 + EXP_W + FRAC_W;
   localparam int MW  = FRAC_W + 1;
   localparam int PW  = 2 * FRAC_W + 2;
   localparam int XW  = EXP_W + 2;
   localparam int CW  = 7;                     // {sign, class1, class2, mode}
   localparam int S1W = 1 + CW + XW + 2 * MW;
   localparam int S2W = 1 + CW + XW + PW;
   localparam int S3W = 1 + CW + XW + MW + 1;
   localparam int S4W = 1 + W + 4;

   localparam logic signed [XW-1:0] c_bias    = XW'(fp_bias(EXP_W));
   localparam logic signed [XW-1:0] c_emax    = XW'((1 << EXP_W) - 1);
   localparam logic [W-2:0]         c_max_fin = (W-1)'(fp_max_finite(EXP_W, FRAC_W));
   localparam logic [W-2:0]         c_inf_mag = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   localparam logic [W-1:0]         c_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
      if (e == '0) begin
         return ZERO;
      end else if (e == '1) begin
         return (f == '0) ? INF : NAN;
      end else begin
         return NORM;
      end
   endfunction

   // Whole pipeline moves together; it only freezes when the output is held
   logic adv;
   assign adv     = !OutValid || OutReady;
   assign InReady = adv;

   // ---------------------------------------------------------------- stage 1
   logic [S1W-1:0]    s1_d, s1_q;
   fp_class_e         cls1, cls2;
   logic [EXP_W-1:0]  e1, e2;
   logic [MW-1:0]     m1, m2;
   logic signed [XW-1:0] s1_exp;

   // Unpack, classify, flush subnormals and form the biased exponent sum
   always_comb begin
      e1     = Operand1[W-2:FRAC_W];
      e2     = Operand2[W-2:FRAC_W];
      cls1   = classify(e1, Operand1[FRAC_W-1:0]);
      cls2   = classify(e2, Operand2[FRAC_W-1:0]);
      m1     = (cls1 == NORM) ? {1'b1, Operand1[FRAC_W-1:0]} : '0;
      m2     = (cls2 == NORM) ? {1'b1, Operand2[FRAC_W-1:0]} : '0;
      s1_exp = $signed({2'b00, e1}) + $signed({2'b00, e2}) - c_bias;
      s1_d   = {InValid, Operand1[W-1] ^ Operand2[W-1], cls1, cls2, RoundMode,
                s1_exp, m1, m2};
   end

   fp_pipe_reg #(.WIDTH(S1W)) u_s1 (
      .clk_i(CLK), .rst_i(RST), .en_i(adv), .d_i(s1_d), .q_o(s1_q)
   );

   // ---------------------------------------------------------------- stage 2
   logic [S2W-1:0] s2_d, s2_q;
   logic [PW-1:0]  prod;

   // Full mantissa product
   always_comb begin
      prod = {{MW{1'b0}}, s1_q[MW +: MW]} * {{MW{1'b0}}, s1_q[0 +: MW]};
      s2_d = {s1_q[S1W-1], s1_q[S1W-2 -: CW], s1_q[2*MW +: XW], prod};
   end

   fp_pipe_reg #(.WIDTH(S2W)) u_s2 (
      .clk_i(CLK), .rst_i(RST), .en_i(adv), .d_i(s2_d), .q_o(s2_q)
   );

   // ---------------------------------------------------------------- stage 3
   logic [S3W-1:0]       s3_d, s3_q;
   logic [PW-1:0]        s2_prod;
   logic [CW-1:0]        s2_ctl;
   logic signed [XW-1:0] s2_exp, s3_exp_d;
   logic                 norm_shift, guard, sticky;
   logic [MW-1:0]        mant_pre, rnd_mant;
   logic                 rnd_carry, rnd_inexact;

   // Normalise the product into mantissa, guard and sticky
   always_comb begin
      s2_prod    = s2_q[0 +: PW];
      s2_ctl     = s2_q[S2W-2 -: CW];
      s2_exp     = s2_q[PW +: XW];
      norm_shift = s2_prod[PW-1];
      if (norm_shift) begin
         mant_pre = s2_prod[PW-1 -: MW];
         guard    = s2_prod[FRAC_W];
         sticky   = |s2_prod[FRAC_W-1:0];
      end else begin
         mant_pre = s2_prod[PW-2 -: MW];
         guard    = s2_prod[FRAC_W-1];
         sticky   = |s2_prod[FRAC_W-2:0];
      end
   end

   fp_round_unit #(.MANT_W(MW)) u_round (
      .mant_i    (mant_pre),
      .guard_i   (guard),
      .sticky_i  (sticky),
      .sign_i    (s2_ctl[6]),
      .mode_i    (s2_ctl[1:0]),
      .mant_o    (rnd_mant),
      .carry_o   (rnd_carry),
      .inexact_o (rnd_inexact)
   );

   // Fold normalisation and rounding carries into the exponent
   always_comb begin
      s3_exp_d = s2_exp + $signed({{(XW-1){1'b0}}, norm_shift})
                        + $signed({{(XW-1){1'b0}}, rnd_carry});
      s3_d     = {s2_q[S2W-1], s2_ctl, s3_exp_d, rnd_mant, rnd_inexact};
   end

   fp_pipe_reg #(.WIDTH(S3W)) u_s3 (
      .clk_i(CLK), .rst_i(RST), .en_i(adv), .d_i(s3_d), .q_o(s3_q)
   );

   // ---------------------------------------------------------------- stage 4
   logic [S4W-1:0]       s4_d, s4_q;
   logic [CW-1:0]        s3_ctl;
   logic signed [XW-1:0] s3_exp;
   logic [MW-1:0]        s3_mant;
   logic                 sgn, any_nan, any_inf, any_zero;
   logic [W-1:0]         res;
   logic [3:0]           flg;

   // Pack the result and apply special-value, overflow and underflow overrides
   always_comb begin
      s3_ctl   = s3_q[S3W-2 -: CW];
      s3_exp   = s3_q[MW+1 +: XW];
      s3_mant  = s3_q[1 +: MW];
      sgn      = s3_ctl[6];
      any_nan  = (s3_ctl[5:4] == NAN)  || (s3_ctl[3:2] == NAN);
      any_inf  = (s3_ctl[5:4] == INF)  || (s3_ctl[3:2] == INF);
      any_zero = (s3_ctl[5:4] == ZERO) || (s3_ctl[3:2] == ZERO);
      res      = {sgn, s3_exp[EXP_W-1:0], s3_mant[FRAC_W-1:0]};
      flg      = '0;
      flg[FLG_NX] = s3_q[0];
      if (any_nan) begin
         res = c_qnan;
         flg = '0;
      end else if (any_inf && any_zero) begin
         res         = c_qnan;
         flg         = '0;
         flg[FLG_NV] = 1'b1;
      end else if (any_inf) begin
         res = {sgn, c_inf_mag};
         flg = '0;
      end else if (any_zero) begin
         res = {sgn, {(W-1){1'b0}}};
         flg = '0;
      end else if (s3_exp >= c_emax) begin
         flg         = '0;
         flg[FLG_OF] = 1'b1;
         flg[FLG_NX] = 1'b1;
         case (s3_ctl[1:0])
            RM_RNE:  res = {sgn, c_inf_mag};
            RM_RTZ:  res = {sgn, c_max_fin};
            RM_RUP:  res = sgn ? {1'b1, c_max_fin} : {1'b0, c_inf_mag};
            default: res = sgn ? {1'b1, c_inf_mag} : {1'b0, c_max_fin};
         endcase
      end else if (s3_exp[XW-1] || (s3_exp == '0) || !s3_mant[FRAC_W]) begin
         // Non-positive exponent (or a mantissa without its hidden one) flushes to zero
         res         = {sgn, {(W-1){1'b0}}};
         flg         = '0;
         flg[FLG_UF] = 1'b1;
         flg[FLG_NX] = 1'b1;
      end
      s4_d = {s3_q[S3W-1], res, flg};
   end

   fp_pipe_reg #(.WIDTH(S4W)) u_s4 (
      .clk_i(CLK), .rst_i(RST), .en_i(adv), .d_i(s4_d), .q_o(s4_q)
   );

   assign OutValid = s4_q[S4W-1];
   assign Result   = s4_q[4 +: W];
   assign Flags    = s4_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Scoreboard bench for fp_mul_pipe (binary32 configuration):
//               directed products, special values, backpressure and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_mul_pipe;
   import fp_mul_pkg::*;

   logic        CLK;
   logic        RST;
   logic        InValid;
   logic        InReady;
   logic [31:0] Operand1;
   logic [31:0] Operand2;
   logic [1:0]  RoundMode;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Result;
   logic [3:0]  Flags;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .InValid  (InValid),
      .InReady  (InReady),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .RoundMode(RoundMode),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Result   (Result),
      .Flags    (Flags)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          acc;
      bit          lat;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         mon_e;
   int          n_tot  = 0;
   int          n_bad  = 0;
   int          cyc    = 0;
   int          n_out  = 0;
   int          n_stall = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_res;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tot++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Output monitor: flow-control rules, stall stability and in-order scoreboard
   always @(negedge CLK) begin
      if (RST) begin
         sb_q.delete();
         prev_stall = 0;
      end else begin
         chk("in_ready", 64'(InReady), 64'(!OutValid || OutReady));
         if (OutValid && !OutReady) begin
            n_stall++;
            if (prev_stall) chk("stall_hold", 64'(Result), 64'(prev_res));
            prev_stall = 1;
            prev_res   = Result;
         end else begin
            prev_stall = 0;
         end
         if (OutValid && sb_q.size() == 0) begin
            chk("spurious_out", 64'(OutValid), 64'd0);
         end else if (OutValid && OutReady) begin
            mon_e = sb_q.pop_front();
            n_out++;
            chk("result", 64'(Result), 64'(mon_e.res));
            chk("flags", 64'(Flags), 64'(mon_e.flg));
            if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'd4);
         end
      end
   end

   // Present one operand pair and record its expected result at acceptance
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input logic [31:0] r, input logic [3:0] f, input bit lat);
      int  n;
      sb_t e;
      Operand1  = a;
      Operand2  = b;
      RoundMode = rm;
      InValid   = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!InReady && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!InReady) begin
         chk("issue_ready", 64'(InReady), 64'd1);
      end else begin
         e.res = r; e.flg = f; e.acc = cyc; e.lat = lat;
         sb_q.push_back(e);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                      input logic [31:0] r, input logic [3:0] f);
      issue(a, b, rm, r, f, 1'b1);
      InValid = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int out_before;
      int stall_before;
      RST = 1'b1; InValid = 1'b0; OutReady = 1'b1;
      Operand1 = '0; Operand2 = '0; RoundMode = RM_RNE;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("reset_outvalid", 64'(OutValid), 64'd0);
      chk("reset_result",   64'(Result),   64'd0);
      chk("reset_flags",    64'(Flags),    64'd0);
      chk("reset_inready",  64'(InReady),  64'd1);

      // Directed products: {a, b, mode, expected result, expected flags}
      one(32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'h0);
      one(32'h3F800001, 32'h3F800001, RM_RNE, 32'h3F800002, 4'h1);
      one(32'h3F800001, 32'h3F800001, RM_RUP, 32'h3F800003, 4'h1);
      one(32'h3F800001, 32'h3F800001, RM_RTZ, 32'h3F800002, 4'h1);
      one(32'h3F800001, 32'h3F800001, RM_RDN, 32'h3F800002, 4'h1);
      one(32'hBF800001, 32'h3F800001, RM_RDN, 32'hBF800003, 4'h1);
      one(32'h3F800001, 32'h3FC00000, RM_RNE, 32'h3FC00002, 4'h1);
      one(32'h3FFFFFFF, 32'h3FFFFFFF, RM_RNE, 32'h407FFFFE, 4'h1);
      one(32'h7F000000, 32'h7F000000, RM_RNE, 32'h7F800000, 4'h5);
      one(32'h7F000000, 32'h7F000000, RM_RTZ, 32'h7F7FFFFF, 4'h5);
      one(32'hFF000000, 32'h7F000000, RM_RUP, 32'hFF7FFFFF, 4'h5);
      one(32'h7F000000, 32'h7F000000, RM_RDN, 32'h7F7FFFFF, 4'h5);
      one(32'h7F800000, 32'h00000000, RM_RNE, 32'h7FC00000, 4'h8);
      one(32'h00800000, 32'h00800000, RM_RNE, 32'h00000000, 4'h3);
      one(32'h7FC00001, 32'h3F800000, RM_RNE, 32'h7FC00000, 4'h0);
      one(32'h80000000, 32'h3F800000, RM_RNE, 32'h80000000, 4'h0);
      one(32'h7F800000, 32'hC0000000, RM_RNE, 32'hFF800000, 4'h0);
      one(32'h00000001, 32'h3F800000, RM_RNE, 32'h00000000, 4'h0);
      one(32'hFF800000, 32'h7FC00000, RM_RNE, 32'h7FC00000, 4'h0);

      // Backpressure: 8 back-to-back exact products by +-2 with a 3-cycle stall
      out_before   = n_out;
      stall_before = n_stall;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [31:0] a;
               logic [31:0] b;
               logic [31:0] r;
               a = 32'h3FC00000 + (32'(i) << 12);
               b = (i % 2 == 1) ? 32'hC0000000 : 32'h40000000;
               r = (a + 32'h00800000) ^ ((i % 2 == 1) ? 32'h80000000 : 32'h0);
               issue(a, b, RM_RNE, r, 4'h0, 1'b0);
            end
            InValid = 1'b0;
         end
         begin
            int n;
            n = 0;
            while (!OutValid && n < 30) begin
               @(negedge CLK);
               n++;
            end
            if (!OutValid) chk("bp_first_out", 64'(OutValid), 64'd1);
            repeat (2) @(posedge CLK);
            #1;
            OutReady = 1'b0;
            repeat (3) @(posedge CLK);
            #1;
            OutReady = 1'b1;
         end
      join
      drain();
      chk("bp_count", 64'(n_out - out_before), 64'd8);
      chk("bp_stall_cycles", 64'(n_stall - stall_before), 64'd3);

      // Reset with three operations in flight
      out_before = n_out;
      issue(32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'h0, 1'b0);
      issue(32'h40000000, 32'h40000000, RM_RNE, 32'h40800000, 4'h0, 1'b0);
      issue(32'h40400000, 32'h40000000, RM_RNE, 32'h40C00000, 4'h0, 1'b0);
      InValid = 1'b0;
      RST     = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_outvalid", 64'(OutValid), 64'd0);
      chk("rst_result",   64'(Result),   64'd0);
      chk("rst_flags",    64'(Flags),    64'd0);
      repeat (10) @(posedge CLK);
      #1;
      chk("rst_no_stale", 64'(n_out - out_before), 64'd0);
      one(32'h40400000, 32'h40400000, RM_RNE, 32'h41100000, 4'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
